// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO and its read/write side stages.
package fifo_pkg;

    // Occupancy of the read-side skid buffer. FIFO-side checkers compare
    // against these values as plain 2-bit constants.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_cnt_e;

endpackage

// File: rtl/rd_pkt_counter.sv
// Beat counter for packet framing: counts pops 0..PKTLEN-1 and flags the last beat.
// The write side uses this counter for its own framing as well.
module rd_pkt_counter #(
    parameter int PKTLEN = 4
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    clr,
    input  logic                    inc,
    output logic [$clog2(PKTLEN):0] beat,
    output logic                    is_last
);

    localparam int CW = $clog2(PKTLEN) + 1;

    logic [CW-1:0] beat_q;
    logic [CW-1:0] beat_d;

    assign is_last = (beat_q == CW'(PKTLEN - 1));
    assign beat    = beat_q;

    // Next beat: clear wins, otherwise advance on each pop and wrap after the last beat.
    always_comb begin
        beat_d = beat_q;
        if (clr) begin
            beat_d = '0;
        end else if (inc) begin
            beat_d = is_last ? '0 : beat_q + CW'(1);
        end
    end

    // Beat register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side egress of the dual-clock FIFO: pops the fall-through FIFO head into a
// 2-entry skid buffer and presents it as a registered valid/ready stream with
// per-packet last tagging.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_EMPTY | no word buffered, out_valid=0
//   ST_ONE   | head holds a word; may pop and dequeue in the same cycle
//   ST_TWO   | head and tail both hold words; popping is stopped
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int PKTLEN = 4
) (
    input  logic             rclk,
    input  logic             rresetb,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             flush,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int CW = $clog2(PKTLEN) + 1;

    skid_cnt_e      count_q;
    skid_cnt_e      count_d;
    logic [DSIZE:0] head_q;
    logic [DSIZE:0] head_d;
    logic [DSIZE:0] tail_q;
    logic [DSIZE:0] tail_d;
    logic [DSIZE:0] word_in;
    logic [CW-1:0]  beat;
    logic           beat_last;
    logic           pop;
    logic           deq;

    // Pop never looks at out_ready, so there is no combinational ready path back to the FIFO.
    assign pop       = !rempty && (count_q != ST_TWO) && !flush;
    assign deq       = out_valid && out_ready;
    assign rinc      = pop;
    assign word_in   = {beat_last, rdata};
    assign out_valid = (count_q != ST_EMPTY);
    assign out_data  = head_q[DSIZE-1:0];
    assign out_last  = head_q[DSIZE];

    rd_pkt_counter #(
        .PKTLEN (PKTLEN)
    ) u_pkt (
        .clk     (rclk),
        .resetb  (rresetb),
        .clr     (flush),
        .inc     (pop),
        .beat    (beat),
        .is_last (beat_last)
    );

    // Skid buffer next state: the head only changes when it is empty or being dequeued,
    // which keeps out_data/out_last stable under backpressure.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            ST_EMPTY: begin
                if (pop) begin
                    head_d  = word_in;
                    count_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (pop && !deq) begin
                    tail_d  = word_in;
                    count_d = ST_TWO;
                end else if (pop && deq) begin
                    head_d = word_in;
                end else if (deq) begin
                    count_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (deq) begin
                    head_d  = tail_q;
                    count_d = ST_ONE;
                end
            end
            default: count_d = ST_EMPTY;
        endcase
        if (flush) begin
            count_d = ST_EMPTY;
        end
    end

    // Occupancy and entry registers.
    always_ff @(posedge rclk or negedge rresetb) begin
        if (!rresetb) begin
            count_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    a_no_pop_when_empty: assert property (@(posedge rclk) disable iff (!rresetb)
        !(rinc && rempty));

    a_count_legal: assert property (@(posedge rclk) disable iff (!rresetb)
        count_q inside {ST_EMPTY, ST_ONE, ST_TWO});

    a_stable_under_stall: assert property (@(posedge rclk) disable iff (!rresetb)
        (out_valid && !out_ready && !flush) |=> ($stable(out_data) && $stable(out_last)));

    a_flush_restarts_packet: assert property (@(posedge rclk) disable iff (!rresetb)
        flush |=> (beat == '0) && !out_valid);

endmodule
